uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//   Configurable UART receiver: the next-generation serial front end for the order-entry path.
//   Adds run-time-free parametrisation of data width, parity and stop bits, a valid/ready output
//   handshake with a one-word holding register, per-word parity/framing error flags,
//   overrun reporting and line-break detection. Sits between the board RX pin and the message parser.
// PARAMETERS
//   CLK_FREQ     100000000  system clock frequency, Hz
//   BAUD_RATE    115200     line rate, baud
//   DATA_BITS    8          data bits per frame, legal 5..9, LSB first on the line
//   PARITY       0          0 = none, 1 = even, 2 = odd
//   STOP_BITS    1          1 or 2
// PORTS
//   clk         in   1          system clock
//   rst         in   1          asynchronous, active-high reset
//   rx          in   1          serial line, idle high, asynchronous to clk
//   rx_data     out  DATA_BITS  received word, stable while rx_valid=1
//   rx_valid    out  1          word available in holding register
//   rx_ready    in   1          consumer accepts word on a clk edge where rx_valid & rx_ready
//   parity_err  out  1          parity mismatch for the word in rx_data (0 when PARITY=0)
//   frame_err   out  1          a stop bit sampled low for the word in rx_data
//   overrun     out  1          one-cycle pulse: completed word dropped because holding reg full
//   break_det   out  1          one-cycle pulse: break condition detected
// BEHAVIOUR
//   Reset (async assert): all outputs 0. Synchroniser stages = 1. State = IDLE. Counters = 0.
//   Sync: 3-flop synchroniser on rx. rx_f = 2-of-3 majority of the three stages.
//   Timing: CPB = (CLK_FREQ + BAUD_RATE/2)/BAUD_RATE (868 at defaults); HALF = CPB/2.
//   Counter width $clog2(CPB+1).
//   FSM states: IDLE, START, DATA, PAR, STOP, BRK.
//   - IDLE: cnt=0, bit=0. rx_f==0 -> START.
//   - START: count to HALF. At HALF, rx_f==0 -> DATA with cnt=0; else -> IDLE (false start, no output).
//   - DATA: sample rx_f when cnt==CPB-1 (bit centre), shift in LSB first, cnt=0.
//     After DATA_BITS samples -> PAR if PARITY!=0, else STOP.
//   - PAR: sample at CPB-1. perr = (XOR(data)^rx_f) != (PARITY==2).
//   - STOP: sample each stop bit at CPB-1. Any low sample sets ferr.
//     After STOP_BITS samples, run the completion step.
//   - BRK: stay until rx_f==1, then -> IDLE.
//   Completion step, evaluated at the last stop-bit sample:
//   - Break: all data bits, the parity bit (if any) and the first stop bit all 0.
//     -> pulse break_det for 1 cycle, no word delivered, go to BRK.
//   - Otherwise go to IDLE and deliver: rx_valid rises 1 cycle after the last stop sample.
//     Delivery loads rx_data, parity_err and frame_err together; a framed-bad word is still delivered.
//   Handshake:
//   - rx_valid holds until a clk edge with rx_ready=1; it then drops next cycle unless reloaded.
//   - rx_data and the error flags are held constant while rx_valid=1.
//   - Completion while rx_valid=1 and rx_ready=0: pulse overrun, discard the new word, keep the old one.
//   - Completion in the same cycle as an accept: load the new word, rx_valid stays 1, no overrun.
//   - rx_ready while rx_valid=0 is ignored.
//   Reset mid-frame: everything returns to the reset values immediately.
//     First frame after release is received normally once its start edge is seen.
//   rx stuck low after a break: no further frames until rx_f returns high.
//   Width rule: DATA_BITS=9 with PARITY!=0 and STOP_BITS=2 is legal (13-bit frame).
// TESTING
//   1. 8N1, send 0xA5 then 0x3C, rx_ready=1 -> two rx_valid words 0xA5, 0x3C; all error flags 0.
//   2. PARITY=1, send 0x07 with parity bit 0 (wrong) -> rx_data=0x07, parity_err=1.
//      Then 0x07 with parity bit 1 -> parity_err=0.
//   3. 8N1, send 0x55 with stop bit 0 followed by idle -> rx_data=0x55, frame_err=1, break_det=0.
//   4. rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once;
//      repeat with rx_ready asserted on the completion cycle -> rx_data=0x22, no overrun.
//   5. Hold rx low 12 bit times -> break_det=1 for 1 cycle, no rx_valid; next 0x5A frame received OK.
//      A 200-cycle low glitch (< HALF=434) -> no START acceptance, no output.
//   6. Assert rst mid-DATA of 0xFF -> outputs 0 immediately; DATA_BITS=7, STOP_BITS=2 run gives 0x7F.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//   Configurable UART receiver for the order-entry serial path. It samples the
//   line at bit centres, checks the optional parity bit and the stop bit(s), and
//   hands each completed word to the consumer through a one-word holding
//   register with a valid/ready handshake. It also reports lost words (overrun)
//   and a line held low across a whole frame (break).
//
//   Parameters
//     CLK_FREQ   system clock frequency in Hz
//     BAUD_RATE  line rate in baud
//     DATA_BITS  data bits per frame, 5..9, sent LSB first
//     PARITY     0 = none, 1 = even, 2 = odd
//     STOP_BITS  1 or 2
//
//   Ports
//     clk         system clock
//     rst         asynchronous active-high reset
//     rx          serial line, idle high, asynchronous to clk
//     rx_data     received word, held stable while rx_valid is high
//     rx_valid    holding register contains a word
//     rx_ready    consumer takes the word on a clk edge with rx_valid & rx_ready
//     parity_err  parity mismatch for the word in rx_data
//     frame_err   a stop bit of the word in rx_data was sampled low
//     overrun     one-cycle pulse: a completed word was dropped (holding reg full)
//     break_det   one-cycle pulse: break condition detected
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int CPB  = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);
    localparam int BW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(HALF);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4,
        S_BRK   = 3'd5
    } state_t;

    // XOR reduction of a data word (even-parity bit of the word).
    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        return ^w;
    endfunction

    logic [2:0]           sync_r;
    logic                 rx_f_s;
    state_t               state_r, state_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [BW-1:0]        bit_r, bit_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 perr_r, perr_s;
    logic                 ferr_r, ferr_s;
    // low_r: parity bit and first stop bit seen so far were all low (break candidate)
    logic                 low_r, low_s;
    logic                 done_s;
    logic                 brk_s;
    logic                 accept_s;

    // Three-stage synchroniser on rx; stages reset to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 3'b111;
        end else begin
            sync_r <= {sync_r[1:0], rx};
        end
    end

    // 2-of-3 majority filter over the synchroniser stages.
    assign rx_f_s = (sync_r[0] & sync_r[1]) | (sync_r[1] & sync_r[2]) | (sync_r[0] & sync_r[2]);

    assign accept_s = rx_valid & rx_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame datapath registers: bit timer, bit index, shifter and error accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= '0;
            bit_r   <= '0;
            shift_r <= '0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            low_r   <= 1'b0;
        end else begin
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            perr_r  <= perr_s;
            ferr_r  <= ferr_s;
            low_r   <= low_s;
        end
    end

    // Next-state and frame sampling logic; done_s marks the last stop-bit sample.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        perr_s  = perr_r;
        ferr_s  = ferr_r;
        low_s   = low_r;
        done_s  = 1'b0;
        brk_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                cnt_s  = '0;
                bit_s  = '0;
                perr_s = 1'b0;
                ferr_s = 1'b0;
                low_s  = 1'b1;
                if (!rx_f_s) begin
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                // Re-check the line half a bit after the falling edge to reject glitches.
                if (cnt_r == CNT_HALF) begin
                    cnt_s = '0;
                    if (!rx_f_s) begin
                        state_s = S_DATA;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    shift_s = {rx_f_s, shift_r[DATA_BITS-1:1]};
                    if (bit_r == DATA_LAST) begin
                        bit_s   = '0;
                        state_s = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_s = bit_r + BIT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_PAR: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    perr_s  = (parity_of(shift_r) ^ rx_f_s) != ODD_PAR;
                    low_s   = low_r & ~rx_f_s;
                    state_s = S_STOP;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s  = '0;
                    ferr_s = ferr_r | ~rx_f_s;
                    // Only the first stop bit takes part in break detection.
                    if (bit_r == '0) begin
                        low_s = low_r & ~rx_f_s;
                    end else begin
                        low_s = low_r;
                    end
                    if (bit_r == STOP_LAST) begin
                        bit_s   = '0;
                        done_s  = 1'b1;
                        brk_s   = (shift_r == '0) && low_s;
                        state_s = brk_s ? S_BRK : S_IDLE;
                    end else begin
                        bit_s = bit_r + BIT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_BRK: begin
                // Hold off new frames until the line has returned high.
                if (rx_f_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_BRK;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Holding register, handshake and event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            break_det <= 1'b0;
            if (done_s && brk_s) begin
                break_det <= 1'b1;
                if (accept_s) begin
                    rx_valid <= 1'b0;
                end
            end else if (done_s) begin
                // A word completing while the old one is still unclaimed is dropped;
                // completing on the accept edge reloads the register seamlessly.
                if (rx_valid && !rx_ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data    <= shift_r;
                    parity_err <= perr_r;
                    frame_err  <= ferr_s;
                    rx_valid   <= 1'b1;
                end
            end else if (accept_s) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 7N2) at 32 clocks per bit.
module tb_uart_rx_cfg;

    localparam int CF   = 3200000;
    localparam int BR   = 100000;
    localparam int CPB  = (CF + BR / 2) / BR;
    localparam int HALF = CPB / 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, bk0, bk1, bk2;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_ovr_cyc = 0;
    int ovc[3] = '{default: 0};
    int bkc[3] = '{default: 0};
    // observed accepted words: {parity_err, frame_err, data zero-extended to 9 bits}
    logic [10:0] obs0[$], obs1[$], obs2[$];

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .break_det(bk0));
    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .break_det(bk1));
    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .rx(rx2), .rx_data(d2), .rx_valid(v2), .rx_ready(rdy2),
        .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .break_det(bk2));

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: words taken by the consumer and event pulses.
    always @(negedge clk) begin
        if (v0 && rdy0) obs0.push_back({pe0, fe0, 1'b0, d0});
        if (v1 && rdy1) obs1.push_back({pe1, fe1, 1'b0, d1});
        if (v2 && rdy2) obs2.push_back({pe2, fe2, 2'b00, d2});
        if (ov0) begin ovc[0] <= ovc[0] + 1; last_ovr_cyc <= cyc; end
        if (ov1) ovc[1] <= ovc[1] + 1;
        if (ov2) ovc[2] <= ovc[2] + 1;
        if (bk0) bkc[0] <= bkc[0] + 1;
        if (bk1) bkc[1] <= bkc[1] + 1;
        if (bk2) bkc[2] <= bkc[2] + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int obs_size(input int d);
        case (d)
            0: return obs0.size();
            1: return obs1.size();
            default: return obs2.size();
        endcase
    endfunction

    function automatic logic [10:0] obs_front(input int d);
        case (d)
            0: return (obs0.size() > 0) ? obs0[0] : 11'h7FF;
            1: return (obs1.size() > 0) ? obs1[0] : 11'h7FF;
            default: return (obs2.size() > 0) ? obs2[0] : 11'h7FF;
        endcase
    endfunction

    task automatic obs_clear(input int d);
        case (d)
            0: obs0.delete();
            1: obs1.delete();
            default: obs2.delete();
        endcase
    endtask

    task automatic drive(input int d, input logic v);
        case (d)
            0: rx0 = v;
            1: rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Drive n line bits LSB first, one bit time each, then two bit times of idle.
    task automatic send(input int d, input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            drive(d, f[i]);
            repeat (CPB) @(posedge clk);
            #1;
        end
        drive(d, 1'b1);
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    // Reference model: build the frame for instance d and predict the outcome.
    task automatic send_model(input int d, input logic [8:0] data, input logic pb,
                              input logic [1:0] stops, output logic [10:0] exp_w,
                              output logic exp_brk);
        int nd    = (d == 2) ? 7 : 8;
        int haspar = (d == 1) ? 1 : 0;
        int nstop = (d == 2) ? 2 : 1;
        logic [15:0] f = 16'h0000;
        int pos = 1;
        int ones = 0;
        logic perr_e, ferr_e;
        for (int i = 0; i < nd; i++) begin
            f[pos] = data[i];
            pos++;
            if (data[i]) ones++;
        end
        if (haspar != 0) begin
            f[pos] = pb;
            pos++;
        end
        for (int s = 0; s < nstop; s++) begin
            f[pos] = stops[s];
            pos++;
        end
        perr_e  = (haspar != 0) && (((ones + (pb ? 1 : 0)) % 2) != 0);
        ferr_e  = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        exp_brk = (data == 9'd0) && (haspar == 0 || pb == 1'b0) && (stops[0] == 1'b0);
        exp_w   = {perr_e, ferr_e, data};
        send(d, f, pos);
    endtask

    task automatic test_reset;
        #3 rst = 1'b1;
        #1;
        n_chk++; if ({v0, d0, pe0, fe0, ov0, bk0} !== 13'd0) begin n_fail++;
            $display("FAIL reset_dut0: got %h expected 0", {v0, d0, pe0, fe0, ov0, bk0}); end
        n_chk++; if ({v1, d1, pe1, fe1, ov1, bk1} !== 13'd0) begin n_fail++;
            $display("FAIL reset_dut1: got %h expected 0", {v1, d1, pe1, fe1, ov1, bk1}); end
        n_chk++; if ({v2, d2, pe2, fe2, ov2, bk2} !== 12'd0) begin n_fail++;
            $display("FAIL reset_dut2: got %h expected 0", {v2, d2, pe2, fe2, ov2, bk2}); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [10:0] e;
        logic b;
        logic [8:0] words[2] = '{9'h0A5, 9'h03C};
        for (int k = 0; k < 2; k++) begin
            obs_clear(0);
            send_model(0, words[k], 1'b0, 2'b11, e, b);
            n_chk++; if (obs0.size() != 1 || obs_front(0) !== e) begin n_fail++;
                $display("FAIL b2b_word%0d: got %h (n=%0d) expected %h", k, obs_front(0), obs0.size(), e); end
        end
    endtask

    task automatic test_parity;
        logic [10:0] e;
        logic b;
        for (int k = 0; k < 2; k++) begin
            obs_clear(1);
            send_model(1, 9'h007, k[0], 2'b11, e, b);
            n_chk++; if (obs1.size() != 1 || obs_front(1) !== e) begin n_fail++;
                $display("FAIL parity_pb%0d: got %h expected %h", k, obs_front(1), e); end
        end
    endtask

    task automatic test_framing;
        logic [10:0] e;
        logic b;
        int bk_before = bkc[0];
        obs_clear(0);
        send_model(0, 9'h055, 1'b0, 2'b10, e, b);
        n_chk++; if (obs0.size() != 1 || obs_front(0) !== e) begin n_fail++;
            $display("FAIL framing_word: got %h expected %h", obs_front(0), e); end
        n_chk++; if (bkc[0] != bk_before) begin n_fail++;
            $display("FAIL framing_nobreak: got %0d break pulses expected 0", bkc[0] - bk_before); end
    endtask

    task automatic test_overrun;
        logic [10:0] e;
        logic b;
        int s, off, target, guard, ov_before;
        rdy0 = 1'b0;
        send_model(0, 9'h011, 1'b0, 2'b11, e, b);
        ov_before = ovc[0];
        s = cyc;
        send_model(0, 9'h022, 1'b0, 2'b11, e, b);
        n_chk++; if (v0 !== 1'b1 || d0 !== 8'h11) begin n_fail++;
            $display("FAIL overrun_hold: got v=%b d=%h expected v=1 d=11", v0, d0); end
        n_chk++; if (ovc[0] != ov_before + 1) begin n_fail++;
            $display("FAIL overrun_pulse: got %0d pulse cycles expected 1", ovc[0] - ov_before); end
        // Same frame again, with a one-cycle accept placed on the completion cycle.
        off = last_ovr_cyc - s;
        ov_before = ovc[0];
        obs0.delete();
        s = cyc;
        target = s + off - 1;
        guard = 0;
        fork
            send_model(0, 9'h022, 1'b0, 2'b11, e, b);
            begin
                while (cyc < target && guard < 20 * CPB) begin
                    @(posedge clk);
                    #1;
                    guard++;
                end
                rdy0 = 1'b1;
                @(posedge clk);
                #1 rdy0 = 1'b0;
            end
        join
        n_chk++; if (v0 !== 1'b1 || d0 !== 8'h22) begin n_fail++;
            $display("FAIL accept_reload: got v=%b d=%h expected v=1 d=22", v0, d0); end
        n_chk++; if (ovc[0] != ov_before) begin n_fail++;
            $display("FAIL accept_no_overrun: got %0d pulses expected 0", ovc[0] - ov_before); end
        n_chk++; if (obs0.size() != 1 || obs_front(0) !== 11'h011) begin n_fail++;
            $display("FAIL accept_old_word: got %h expected 011", obs_front(0)); end
        rdy0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 obs0.delete();
    endtask

    task automatic test_break;
        logic [10:0] e;
        logic b;
        int bk_before = bkc[0];
        obs_clear(0);
        // Short low glitch must not be taken as a start bit.
        rx0 = 1'b0;
        repeat (HALF / 2) @(posedge clk);
        #1 rx0 = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        #1;
        n_chk++; if (obs0.size() != 0 || bkc[0] != bk_before) begin n_fail++;
            $display("FAIL glitch: got %0d words %0d breaks expected 0 0", obs0.size(), bkc[0] - bk_before); end
        rx0 = 1'b0;
        repeat (12 * CPB) @(posedge clk);
        #1 rx0 = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        n_chk++; if (bkc[0] != bk_before + 1) begin n_fail++;
            $display("FAIL break_pulse: got %0d pulse cycles expected 1", bkc[0] - bk_before); end
        n_chk++; if (obs0.size() != 0) begin n_fail++;
            $display("FAIL break_noword: got %0d words expected 0", obs0.size()); end
        send_model(0, 9'h05A, 1'b0, 2'b11, e, b);
        n_chk++; if (obs0.size() != 1 || obs_front(0) !== e) begin n_fail++;
            $display("FAIL after_break: got %h expected %h", obs_front(0), e); end
    endtask

    task automatic test_reset_midframe;
        logic [10:0] e;
        logic b;
        rdy0 = 1'b0;
        send_model(0, 9'h05A, 1'b0, 2'b11, e, b);
        fork
            send_model(0, 9'h0FF, 1'b0, 2'b11, e, b);
            begin
                repeat (3 * CPB) @(posedge clk);
                #1 rst = 1'b1;
                #1;
                n_chk++; if ({v0, d0, pe0, fe0, ov0, bk0} !== 13'd0) begin n_fail++;
                    $display("FAIL midframe_reset: got %h expected 0", {v0, d0, pe0, fe0, ov0, bk0}); end
                @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        rdy0 = 1'b1;
        obs0.delete();
        send_model(0, 9'h0FF, 1'b0, 2'b11, e, b);
        n_chk++; if (obs0.size() != 1 || obs_front(0) !== e) begin n_fail++;
            $display("FAIL post_reset_word: got %h expected %h", obs_front(0), e); end
        obs_clear(2);
        send_model(2, 9'h07F, 1'b0, 2'b11, e, b);
        n_chk++; if (obs2.size() != 1 || obs_front(2) !== e) begin n_fail++;
            $display("FAIL 7n2_word: got %h expected %h", obs_front(2), e); end
    endtask

    task automatic test_random(input int d, input int nframes);
        logic [10:0] e;
        logic b;
        logic [8:0] data;
        logic pb;
        logic [1:0] stops;
        int bk_before;
        int nd = (d == 2) ? 7 : 8;
        for (int k = 0; k < nframes; k++) begin
            data  = 9'($urandom_range(0, (1 << nd) - 1));
            if ($urandom_range(0, 4) == 0) data = 9'd0;
            pb    = 1'($urandom_range(0, 1));
            stops = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            bk_before = bkc[d];
            obs_clear(d);
            send_model(d, data, pb, stops, e, b);
            if (b) begin
                n_chk++; if (bkc[d] != bk_before + 1 || obs_size(d) != 0) begin n_fail++;
                    $display("FAIL rand%0d_break: got %0d pulses %0d words expected 1 0", d, bkc[d] - bk_before, obs_size(d)); end
            end else begin
                n_chk++; if (obs_size(d) != 1 || obs_front(d) !== e || bkc[d] != bk_before) begin n_fail++;
                    $display("FAIL rand%0d_word: got %h (n=%0d) expected %h", d, obs_front(d), obs_size(d), e); end
            end
        end
        n_chk++; if (ovc[d] != 0 && d != 0) begin n_fail++;
            $display("FAIL rand%0d_overrun: got %0d pulses expected 0", d, ovc[d]); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_parity();
        test_framing();
        test_overrun();
        test_break();
        test_reset_midframe();
        test_random(0, 10);
        test_random(1, 10);
        test_random(2, 10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
